// File: rtl/cv32e41s_log_event_arbiter.sv
// cv32e41s_log_event_arbiter
//
// Shares one log/trace sink between N_SRC fire-and-forget event sources.
// Each source pulse {pc, hart[3:0]} is captured into a 1-entry per-source slot.
// A round-robin arbiter moves one held event per cycle into a DEPTH-entry FIFO.
// The FIFO drains to the sink over a valid/ready handshake. The pipeline is never
// stalled: an event that cannot be held is dropped and reported on drop_o.
//
// Optional feature: define CV32E41S_LOG_DROP_CNT_EN to add drop_cnt_o, a saturating
// 16-bit count of dropped events.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   evt_valid_i    per-source single-cycle event pulse
//   evt_pc_i       per-source PC, source k on [32k+31:32k]
//   mhartid_i      hart id, bits [3:0] stored with each event
//   log_valid_o    FIFO head valid
//   log_ready_i    sink accepts head
//   log_src_o      source index of head entry
//   log_pc_o       PC of head entry
//   log_hart_o     hart id captured with head entry
//   fifo_level_o   FIFO occupancy
//   drop_o         registered pulse: at least one event lost in the previous cycle
//   drop_cnt_o     (CV32E41S_LOG_DROP_CNT_EN only) saturating drop count
module cv32e41s_log_event_arbiter #(
  parameter int unsigned N_SRC = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [N_SRC-1:0]                         evt_valid_i,
  input  logic [N_SRC*32-1:0]                      evt_pc_i,
  input  logic [31:0]                              mhartid_i,
  output logic                                     log_valid_o,
  input  logic                                     log_ready_i,
  output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] log_src_o,
  output logic [31:0]                              log_pc_o,
  output logic [3:0]                               log_hart_o,
  output logic [$clog2(DEPTH):0]                   fifo_level_o,
  output logic                                     drop_o
`ifdef CV32E41S_LOG_DROP_CNT_EN
  ,
  output logic [15:0]                              drop_cnt_o
`endif
);

  localparam int unsigned SRCW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned LW   = AW + 1;

  // Per-source holding slots
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] cap;
  logic [N_SRC-1:0] drop_vec;
  logic [31:0]      slot_pc_q   [N_SRC];
  logic [3:0]       slot_hart_q [N_SRC];

  // Round-robin pointer and grant
  logic [SRCW-1:0]  rr_q, rr_d;
  logic             gnt_valid;
  logic [SRCW-1:0]  gnt_idx;

  // FIFO storage
  logic [SRCW-1:0]  fifo_src_q  [DEPTH];
  logic [31:0]      fifo_pc_q   [DEPTH];
  logic [3:0]       fifo_hart_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]    level_q;

  logic             drop_q;
  logic             pop;
  logic             push_ok;

  logic             unused_hart;
  assign unused_hart = ^mhartid_i[31:4];

  assign pop     = log_valid_o & log_ready_i;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = (level_q < LW'(DEPTH)) | pop;

  // Search pend starting at rr_q, wrapping modulo N_SRC.
  always_comb begin
    int unsigned j;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    if (push_ok) begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        j = (32'(rr_q) + i) % N_SRC;
        if (!gnt_valid && pend_q[j]) begin
          gnt_valid = 1'b1;
          gnt_idx   = SRCW'(j);
        end
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_valid) begin
      rr_d = SRCW'((32'(gnt_idx) + 1) % N_SRC);
    end
  end

  // A new pulse lands if the slot is empty or is being emptied by this cycle's grant.
  always_comb begin
    pend_d   = pend_q;
    cap      = '0;
    drop_vec = '0;
    if (gnt_valid) begin
      pend_d[gnt_idx] = 1'b0;
    end
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (evt_valid_i[k]) begin
        if (!pend_q[k] || (gnt_valid && (gnt_idx == SRCW'(k)))) begin
          cap[k]    = 1'b1;
          pend_d[k] = 1'b1;
        end else begin
          drop_vec[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      rr_q   <= '0;
      drop_q <= 1'b0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
        slot_pc_q[k]   <= '0;
        slot_hart_q[k] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      rr_q   <= rr_d;
      drop_q <= |drop_vec;
      for (int unsigned k = 0; k < N_SRC; k++) begin
        if (cap[k]) begin
          slot_pc_q[k]   <= evt_pc_i[32*k +: 32];
          slot_hart_q[k] <= mhartid_i[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      for (int unsigned d = 0; d < DEPTH; d++) begin
        fifo_src_q[d]  <= '0;
        fifo_pc_q[d]   <= '0;
        fifo_hart_q[d] <= '0;
      end
    end else begin
      if (gnt_valid) begin
        fifo_src_q[wr_ptr_q]  <= gnt_idx;
        fifo_pc_q[wr_ptr_q]   <= slot_pc_q[gnt_idx];
        fifo_hart_q[wr_ptr_q] <= slot_hart_q[gnt_idx];
        wr_ptr_q              <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (gnt_valid && !pop) begin
        level_q <= level_q + LW'(1);
      end else if (!gnt_valid && pop) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

`ifdef CV32E41S_LOG_DROP_CNT_EN
  logic [15:0] drop_cnt_q;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int unsigned k = 0; k < N_SRC; k++) begin
      drop_sum = drop_sum + 17'(drop_vec[k]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else if (drop_sum[16]) begin
      drop_cnt_q <= 16'hFFFF;
    end else begin
      drop_cnt_q <= drop_sum[15:0];
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign log_valid_o  = (level_q != '0);
  assign log_src_o    = fifo_src_q[rd_ptr_q];
  assign log_pc_o     = fifo_pc_q[rd_ptr_q];
  assign log_hart_o   = fifo_hart_q[rd_ptr_q];
  assign fifo_level_o = level_q;
  assign drop_o       = drop_q;

endmodule
